// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared state encoding and line constants for the USB transmit path
package usb_tx_pkg;
    typedef enum logic [1:0] {IDLE, SEND, STUFF} state_e;
    localparam int   STUFF_LIMIT_DEF = 6;
    localparam logic NRZI_IDLE_LEVEL = 1'b0;
endpackage

// File: rtl/bitstuff_nrzi_encode_if.sv
// bitstuff_nrzi_encode_if: raw packet bit handshake in, NRZI line bit out
interface bitstuff_nrzi_encode_if;
    logic pkt_bit;
    logic pkt_valid;
    logic pkt_ready;
    logic nrzi_out_bit;
    logic nrzi_sending;
    logic pkt_done;
    modport master (output pkt_bit, pkt_valid, input pkt_ready, nrzi_out_bit, nrzi_sending, pkt_done);
    modport slave  (input pkt_bit, pkt_valid, output pkt_ready, nrzi_out_bit, nrzi_sending, pkt_done);
endinterface

// File: rtl/ones_counter.sv
// ones_counter: run length of consecutive ones, saturating, presettable to 1
module ones_counter
    import usb_tx_pkg::*;
#(
    parameter logic [2:0] LIMIT = 3'(STUFF_LIMIT_DEF)
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       inc,
    input  logic       pre,
    output logic [2:0] cnt_o
);
    logic [2:0] cnt_q, cnt_d;
    assign cnt_o = cnt_q;
    // preset wins over clear, clear over increment; increment stops at LIMIT
    always_comb cnt_d = pre ? 3'd1 : clr ? 3'd0 : (inc && cnt_q < LIMIT) ? cnt_q + 3'd1 : cnt_q;
    // the SYNC pattern ends in a 1, so the idle count starts at 1
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) cnt_q <= 3'd1;
        else          cnt_q <= cnt_d;
endmodule

// File: rtl/bitstuff_nrzi_encode.sv
// bitstuff_nrzi_encode: USB bit stuffing followed by NRZI encoding, one bit per cycle
module bitstuff_nrzi_encode
    import usb_tx_pkg::*;
#(
    parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
    input logic                    clock,
    input logic                    reset_n,
    bitstuff_nrzi_encode_if.slave  bus
);
    localparam logic [2:0] LIM = 3'(STUFF_LIMIT);
    state_e     state_q, state_d;
    logic       level_q, level_d;
    logic       sending_q, sending_d;
    logic       done_q, done_d;
    logic       cnt_clr, cnt_inc, cnt_pre;
    logic [2:0] ones_cnt;

    ones_counter #(.LIMIT(LIM)) u_ones (
        .clock  (clock),
        .reset_n(reset_n),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .pre    (cnt_pre),
        .cnt_o  (ones_cnt)
    );

    assign bus.pkt_ready    = state_q != STUFF;
    assign bus.nrzi_out_bit = level_q;
    assign bus.nrzi_sending = sending_q;
    assign bus.pkt_done     = done_q;

    // a 1 keeps the line level, a 0 toggles it; a stuffed 0 always toggles
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        sending_d = sending_q;
        done_d    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        cnt_pre   = 1'b0;
        if (state_q == STUFF) begin
            level_d   = ~level_q;
            sending_d = 1'b1;
            cnt_clr   = 1'b1;
            state_d   = SEND;
        end else if (bus.pkt_valid) begin
            level_d   = bus.pkt_bit ? level_q : ~level_q;
            sending_d = 1'b1;
            cnt_inc   = bus.pkt_bit;
            cnt_clr   = ~bus.pkt_bit;
            state_d   = (bus.pkt_bit && ones_cnt == LIM - 3'd1) ? STUFF : SEND;
        end else begin
            level_d   = NRZI_IDLE_LEVEL;
            sending_d = 1'b0;
            cnt_pre   = 1'b1;
            done_d    = state_q == SEND;
            state_d   = IDLE;
        end
    end

    // state and registered line outputs; reset parks the line at idle K
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state_q   <= IDLE;
            level_q   <= NRZI_IDLE_LEVEL;
            sending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            sending_q <= sending_d;
            done_q    <= done_d;
        end
endmodule

// File: tb/tb_bitstuff_nrzi_encode.sv
// tb_bitstuff_nrzi_encode: directed checks of stuffing, NRZI levels, handshake and reset
module tb_bitstuff_nrzi_encode;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    bitstuff_nrzi_encode_if bus ();

    bitstuff_nrzi_encode dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [2:0] exp);
        chk(tag, {bus.nrzi_out_bit, bus.nrzi_sending, bus.pkt_done}, exp);
    endtask

    task automatic rdy(input string tag, input logic exp);
        chk(tag, {2'b00, bus.pkt_ready}, {2'b00, exp});
    endtask

    task automatic cyc(input logic b, input logic v);
        bus.pkt_bit   = b;
        bus.pkt_valid = v;
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.pkt_bit   = 1'b0;
        bus.pkt_valid = 1'b0;
        #12;
        outs("reset_outs", 3'b000);
        rdy("reset_ready", 1'b1);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        outs("idle_hold", 3'b000);

        // 1,0,0,1 -> 0,1,0,0 then done
        cyc(1, 1); outs("p1_b0", 3'b010);
        cyc(0, 1); outs("p1_b1", 3'b110);
        cyc(0, 1); outs("p1_b2", 3'b010);
        cyc(1, 1); outs("p1_b3", 3'b010);
        cyc(0, 0); outs("p1_done", 3'b001);
        cyc(0, 0); outs("p1_idle", 3'b000);

        // five 1s, stall, stuffed 0, held 0
        for (int i = 0; i < 5; i++) begin
            rdy("p2_ready_ones", 1'b1);
            cyc(1, 1);
            outs("p2_one", 3'b010);
        end
        rdy("p2_ready_stuff", 1'b0);
        cyc(0, 1); outs("p2_stuff", 3'b110);
        rdy("p2_ready_after", 1'b1);
        cyc(0, 1); outs("p2_held0", 3'b010);
        cyc(0, 0); outs("p2_done", 3'b001);
        cyc(0, 0); outs("p2_idle", 3'b000);

        // packet ending on the fifth 1 still gets its stuffed bit
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1);
            outs("p3_one", 3'b010);
        end
        cyc(0, 0); outs("p3_stuff", 3'b110);
        cyc(0, 0); outs("p3_done", 3'b001);
        cyc(0, 0); outs("p3_idle", 3'b000);

        // eight 0s alternate, never stall
        for (int i = 0; i < 8; i++) begin
            rdy("p4_ready", 1'b1);
            cyc(0, 1);
            outs("p4_zero", (i % 2 == 0) ? 3'b110 : 3'b010);
        end
        cyc(0, 0); outs("p4_done", 3'b001);
        cyc(0, 0); outs("p4_idle", 3'b000);

        // a 0 clears the run: 1111 0 11111 must not stuff
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1);
            outs("p5_one_a", 3'b010);
        end
        cyc(0, 1); outs("p5_zero", 3'b110);
        for (int i = 0; i < 5; i++) begin
            rdy("p5_ready", 1'b1);
            cyc(1, 1);
            outs("p5_one_b", 3'b110);
        end
        rdy("p5_ready_end", 1'b1);
        cyc(0, 0); outs("p5_done", 3'b001);

        // back-to-back packets with one idle cycle; second starts at level 0
        cyc(0, 1); outs("p6a_b0", 3'b110);
        cyc(0, 0); outs("p6a_done", 3'b001);
        cyc(1, 1); outs("p6b_b0", 3'b010);
        cyc(0, 1); outs("p6b_b1", 3'b110);
        cyc(0, 0); outs("p6b_done", 3'b001);
        cyc(0, 0); outs("p6_idle", 3'b000);

        // reach STUFF at line level J, then reset asynchronously
        cyc(0, 1); outs("p7_zero", 3'b110);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1);
            outs("p7_one", 3'b110);
        end
        rdy("p7_in_stuff", 1'b0);
        bus.pkt_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        outs("p7_async_reset", 3'b000);
        rdy("p7_reset_ready", 1'b1);
        @(negedge clock);
        reset_n = 1'b1;
        cyc(1, 1); outs("p8_b0", 3'b010);
        cyc(0, 1); outs("p8_b1", 3'b110);
        cyc(0, 0); outs("p8_done", 3'b001);
        cyc(0, 0); outs("p8_idle", 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bitstuff_nrzi_encode.md
BITSTUFF_NRZI_ENCODE -- requirements
Module: bitstuff_nrzi_encode

Interface
REQ-001 Parameter: STUFF_LIMIT, default 6, consecutive-ones count that forces a stuffed zero.
REQ-002 clock  input  1  single clock; all state updates on posedge clock.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 pkt_bit  input  1  raw packet bit, transmit order (PID/data LSB-first), valid when pkt_valid=1.
REQ-005 pkt_valid  input  1  upstream has a bit; a cycle with pkt_valid=0 (outside STUFF) ends the packet.
REQ-006 pkt_ready  output  1  bit accepted this cycle when pkt_valid&pkt_ready; combinational from state only.
REQ-007 nrzi_out_bit  output  1  registered NRZI line level to the DP/DM encoder (1=J, 0=K).
REQ-008 nrzi_sending  output  1  registered; high while nrzi_out_bit carries packet/stuff bits.
REQ-009 pkt_done  output  1  registered one-cycle pulse on the cycle nrzi_sending falls.

Function
REQ-010 FSM states SHALL be IDLE, SEND, STUFF; internal state: level (1b), ones_cnt (3b).
REQ-011 pkt_ready SHALL be 1 in IDLE and SEND, 0 in STUFF.
REQ-012 IDLE or SEND with pkt_valid=1 SHALL accept pkt_bit; next nrzi_out_bit = level if bit=1, ~level if bit=0; level updated to that value; nrzi_sending<=1.
REQ-013 On an accepted 1, ones_cnt SHALL increment; on an accepted 0, ones_cnt SHALL clear to 0.
REQ-014 If an accepted 1 makes ones_cnt equal STUFF_LIMIT, next state SHALL be STUFF; otherwise SEND.
REQ-015 STUFF SHALL register nrzi_out_bit=~level (stuffed zero), update level, clear ones_cnt, keep nrzi_sending=1, go to SEND unconditionally; pkt_bit ignored.
REQ-016 A stuffed bit SHALL be emitted even if pkt_valid falls after the bit that reached STUFF_LIMIT.
REQ-017 SEND with pkt_valid=0 SHALL set nrzi_sending<=0, pulse pkt_done, go to IDLE.
REQ-018 On entering IDLE (and at reset), level SHALL be 0 (K, matching SYNC's final K) and ones_cnt SHALL be 1 (SYNC's final 1 counts toward stuffing).
REQ-019 IDLE with pkt_valid=0 SHALL hold: nrzi_sending=0, pkt_done=0, nrzi_out_bit=0.
REQ-020 Latency: accepted bit appears on nrzi_out_bit exactly one cycle after acceptance; no gaps within a packet except none (stuff bits occupy their own cycle).
REQ-021 ones_cnt SHALL never exceed STUFF_LIMIT; no wrap-around permitted.
REQ-022 Upstream SHALL hold pkt_bit/pkt_valid stable while pkt_ready=0; the block SHALL not drop or duplicate bits.
REQ-023 A new packet SHALL start only from IDLE; back-to-back packets require at least one pkt_valid=0 cycle.

Reset
REQ-024 Asserting reset_n=0 at any time, including mid-packet or in STUFF, SHALL immediately force IDLE, nrzi_out_bit=0, nrzi_sending=0, pkt_done=0, level=0, ones_cnt=1.
REQ-025 After deassertion, first acceptance SHALL occur no earlier than the first posedge with reset_n=1.

Structure
REQ-026 Shared package usb_tx_pkg SHALL hold the state enum, STUFF_LIMIT default, and NRZI_IDLE_LEVEL=0.
REQ-027 One sub-module, ones_counter (clear/inc/preset-to-1, saturating at STUFF_LIMIT), SHALL be instantiated.
REQ-028 Outputs SHALL connect directly to the DP/DM encoder's nrzi_in_bit/nrzi_sending inputs.

Verification
REQ-029 From IDLE, bits 1,0,0,1 then pkt_valid=0 -> nrzi_out_bit 0,1,0,0 on cycles t+1..t+4; nrzi_sending high 4 cycles; pkt_done pulse at t+5.
REQ-030 Bits 1,1,1,1,1,0 -> outputs 0,0,0,0,0,1(stuff),0; pkt_ready=0 exactly one cycle after fifth 1 accepted; bit 0 held and taken next cycle.
REQ-031 Packet ending on the fifth 1 (pkt_valid drops) -> stuffed bit still emitted, nrzi_sending high 6 cycles, then pkt_done.
REQ-032 Eight consecutive 0s -> output alternates 1,0,1,0,1,0,1,0; no stuff, pkt_ready constant 1.
REQ-033 reset_n pulsed low during STUFF -> outputs 0 asynchronously; next packet bits 1,0 -> 0,1 (level and ones_cnt reinitialized).
REQ-034 Two packets separated by one idle cycle -> second packet starts at level 0; pkt_done pulses once per packet.
